// File: rtl/banco_registros_if.sv
// banco_registros_if: bus bundle for the general-purpose register file.
//   master : drives the write port (we_i, rd_addr_i, wd_i) and the read
//            addresses (rs_addr_i, rt_addr_i, dbg_addr_i); samples the read data
//            and the write counter.
//   slave  : the register file itself.
//   Parameters N (data width) and ADDR_W (address width) must match the
//   banco_registros instance that uses this bundle.
`timescale 1ns/1ps
interface banco_registros_if #(
   parameter int N      = 32,
   parameter int ADDR_W = 5
);
   logic              we_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [N-1:0]      wd_i;
   logic [ADDR_W-1:0] rs_addr_i;
   logic [ADDR_W-1:0] rt_addr_i;
   logic [N-1:0]      rs_data_o;
   logic [N-1:0]      rt_data_o;
   logic [ADDR_W-1:0] dbg_addr_i;
   logic [N-1:0]      dbg_data_o;
   logic [15:0]       wr_count_o;

   modport master (
      output we_i, rd_addr_i, wd_i, rs_addr_i, rt_addr_i, dbg_addr_i,
      input  rs_data_o, rt_data_o, dbg_data_o, wr_count_o
   );

   modport slave (
      input  we_i, rd_addr_i, wd_i, rs_addr_i, rt_addr_i, dbg_addr_i,
      output rs_data_o, rt_data_o, dbg_data_o, wr_count_o
   );
endinterface

// File: rtl/banco_registros.sv
// banco_registros: general-purpose register file for the single-cycle datapath.
//   2**ADDR_W registers of N bits, register 0 hard-wired to zero.
//   Ports:
//     clk_i  - single clock, all state changes on the rising edge
//     rst_i  - synchronous active-high reset; clears registers and counter,
//              beats a simultaneous write, forces all read ports to 0 while high
//     bus    - banco_registros_if.slave:
//                we_i/rd_addr_i/wd_i   synchronous write port
//                rs_addr_i/rs_data_o   async read port A (ALU a_i)
//                rt_addr_i/rt_data_o   async read port B (ALU b_i / store data)
//                dbg_addr_i/dbg_data_o async debug read port (board display)
//                wr_count_o            accepted writes, saturating at 16'hFFFF
//   Build option: define REGFILE_BYPASS_EN to make a write visible on the read
//   ports in the same cycle (write-through). Without it, reads return stored
//   contents only and write-to-read latency is one clock.
`timescale 1ns/1ps
module banco_registros #(
   parameter int N      = 32,
   parameter int ADDR_W = 5
) (
   input logic            clk_i,
   input logic            rst_i,
   banco_registros_if.slave bus
);
   localparam int unsigned NREG = 2**ADDR_W;

   logic [N-1:0] regs [0:NREG-1];
   logic [15:0]  wr_count;
   logic         wr_en;
   logic [N-1:0] rs_data;
   logic [N-1:0] rt_data;
   logic [N-1:0] dbg_data;

   // Writes to register 0 are dropped entirely, including from the count.
   assign wr_en = bus.we_i && (bus.rd_addr_i != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         wr_count <= '0;
      end else if (wr_en) begin
         regs[bus.rd_addr_i] <= bus.wd_i;
         if (wr_count != '1) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

   always_comb begin
      rs_data  = regs[bus.rs_addr_i];
      rt_data  = regs[bus.rt_addr_i];
      dbg_data = regs[bus.dbg_addr_i];
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes address 0, so a match implies a nonzero address.
      if (wr_en) begin
         if (bus.rs_addr_i == bus.rd_addr_i)  rs_data  = bus.wd_i;
         if (bus.rt_addr_i == bus.rd_addr_i)  rt_data  = bus.wd_i;
         if (bus.dbg_addr_i == bus.rd_addr_i) dbg_data = bus.wd_i;
      end
`endif
      // Zero forcing is applied last so it overrides both storage and bypass.
      if (rst_i || bus.rs_addr_i == '0)  rs_data  = '0;
      if (rst_i || bus.rt_addr_i == '0)  rt_data  = '0;
      if (rst_i || bus.dbg_addr_i == '0) dbg_data = '0;
   end

   assign bus.rs_data_o  = rs_data;
   assign bus.rt_data_o  = rt_data;
   assign bus.dbg_data_o = dbg_data;
   assign bus.wr_count_o = wr_count;
endmodule

// File: tb/tb_banco_registros.sv
`timescale 1ns/1ps
module tb_banco_registros;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   banco_registros_if #(.N(32), .ADDR_W(5)) bus ();

   banco_registros #(.N(32), .ADDR_W(5)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        r;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  a_rs;
      logic [4:0]  a_rt;
      logic [4:0]  a_dbg;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      logic [31:0] e_dbg;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vec [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 2ns later,
   // before the next rising edge commits the cycle.
   task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c);
      @(negedge clk);
      rst           = r;
      bus.we_i      = w;
      bus.rd_addr_i = wa;
      bus.wd_i      = d;
      bus.rs_addr_i = a;
      bus.rt_addr_i = b;
      bus.dbg_addr_i = c;
      #2;
   endtask

   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {4{b}} ^ 32'h5A5A_5A5A;
   endfunction

   initial begin
      vec[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        16'd0};
      vec[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
      vec[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd1, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        16'd1};
      vec[3] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 5'd5,  32'h0,        32'h0,        32'hDEADBEEF, 16'd1};
      vec[4] = '{1'b0, 1'b1, 5'd7,  32'h1,        5'd5,  5'd0, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        16'd1};
      vec[5] = '{1'b0, 1'b1, 5'd9,  32'hCAFEF00D, 5'd7,  5'd5, 5'd7,  32'h1,        32'hDEADBEEF, 32'h1,        16'd2};
      vec[6] = '{1'b0, 1'b1, 5'd31, 32'h80000000, 5'd9,  5'd7, 5'd9,  32'hCAFEF00D, 32'h1,        32'hCAFEF00D, 16'd3};
      vec[7] = '{1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd9, 5'd31, 32'h80000000, 32'hCAFEF00D, 32'h80000000, 16'd4};
      vec[8] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd0, 5'd0,  32'h80000000, 32'h0,        32'h0,        16'd4};

      rst = 1'b1;
      bus.we_i = 1'b0; bus.rd_addr_i = '0; bus.wd_i = '0;
      bus.rs_addr_i = '0; bus.rt_addr_i = '0; bus.dbg_addr_i = '0;
      repeat (2) @(posedge clk);

      // Reset state
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd5);
      check("reset_cnt", {16'h0, bus.wr_count_o}, 32'h0);
      check("reset_rs", bus.rs_data_o, 32'h0);

      // Fill every register, then reset for two cycles
      for (int i = 1; i < 32; i++) drive(1'b0, 1'b1, i[4:0], pat(i), 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd20, 5'd31);
      check("fill_rs", bus.rs_data_o, pat(10));
      check("fill_rt", bus.rt_data_o, pat(20));
      check("fill_dbg", bus.dbg_data_o, pat(31));
      check("fill_cnt", {16'h0, bus.wr_count_o}, 32'd31);
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd7);
      check("rst_hi_rs", bus.rs_data_o, 32'h0);
      check("rst_hi_rt", bus.rt_data_o, 32'h0);
      check("rst_hi_dbg", bus.dbg_data_o, 32'h0);
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd7);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
      check("post_rst_cnt", {16'h0, bus.wr_count_o}, 32'h0);
      for (int a = 0; a < 32; a++) begin
         bus.rs_addr_i = a[4:0];
         bus.rt_addr_i = 5'(31 - a);
         bus.dbg_addr_i = a[4:0];
         #0.5;
         check($sformatf("clr_rs%0d", a), bus.rs_data_o, 32'h0);
         check($sformatf("clr_rt%0d", a), bus.rt_data_o, 32'h0);
         check($sformatf("clr_dbg%0d", a), bus.dbg_data_o, 32'h0);
      end

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         drive(vec[i].r, vec[i].we, vec[i].wa, vec[i].wd, vec[i].a_rs, vec[i].a_rt, vec[i].a_dbg);
         check($sformatf("v%0d_rs", i), bus.rs_data_o, vec[i].e_rs);
         check($sformatf("v%0d_rt", i), bus.rt_data_o, vec[i].e_rt);
         check($sformatf("v%0d_dbg", i), bus.dbg_data_o, vec[i].e_dbg);
         check($sformatf("v%0d_cnt", i), {16'h0, bus.wr_count_o}, {16'h0, vec[i].e_cnt});
      end

      // Read and write of r7 in the same cycle (r7 holds 1)
      drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd0);
`ifdef REGFILE_BYPASS_EN
      check("rw_same_rs", bus.rs_data_o, 32'h12345678);
      check("rw_same_rt", bus.rt_data_o, 32'h12345678);
`else
      check("rw_same_rs", bus.rs_data_o, 32'h1);
      check("rw_same_rt", bus.rt_data_o, 32'h1);
`endif
      check("rw_same_dbg0", bus.dbg_data_o, 32'h0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0);
      check("rw_next_rs", bus.rs_data_o, 32'h12345678);
      check("rw_next_cnt", {16'h0, bus.wr_count_o}, 32'd5);

      // Reset and write on the same edge
      drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 5'd31);
      check("rstwr_r3", bus.rs_data_o, 32'h0);
      check("rstwr_r7", bus.rt_data_o, 32'h0);
      check("rstwr_r31", bus.dbg_data_o, 32'h0);
      check("rstwr_cnt", {16'h0, bus.wr_count_o}, 32'h0);

      // Counter saturation
      for (int i = 0; i < 65534; i++) drive(1'b0, 1'b1, 5'd1, i, 5'd2, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd0);
      check("sat_fffe", {16'h0, bus.wr_count_o}, 32'h0000FFFE);
      check("sat_r1", bus.rs_data_o, 32'd65533);
      drive(1'b0, 1'b1, 5'd2, 32'h22, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd0, 5'd0);
      check("sat_ffff", {16'h0, bus.wr_count_o}, 32'h0000FFFF);
      check("sat_r2", bus.rs_data_o, 32'h22);
      drive(1'b0, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd0);
      check("sat_hold", {16'h0, bus.wr_count_o}, 32'h0000FFFF);
      check("sat_r3", bus.rs_data_o, 32'h33);
      check("sat_r4", bus.rt_data_o, 32'h44);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
